// File: rtl/axi_lite_rd_arbiter.sv
// axi_lite_rd_arbiter
// Shares one AXI4-Lite read port toward the memory fabric between two
// requesters (s0 = instruction fetch, s1 = data/debug read). Exactly one
// transaction is in flight at a time: arbitrate in IDLE, present a registered
// AR in ADDR, then route the R beat back to the granted requester in DATA.
// Ties are broken round-robin against the last completed grant.
//
// Ports:
//   CLK, RSTN              clock (rising edge), async active-low reset
//   s0_axi_* / s1_axi_*    requester AR (valid/ready/addr/prot) and R
//                          (valid/ready/data/resp) channels
//   m_axi_*                fabric AR (registered valid/addr/prot) and R channels
//
// Optional build macro AXI_RD_ARB_TIMEOUT_EN: adds an R-wait watchdog. After
// TIMEOUT_CYCLES DATA cycles without m_axi_rvalid the granted requester gets a
// SLVERR beat (ERR), then the late fabric beat is drained and dropped (DRAIN).
//
// state | meaning
// IDLE  | no transaction; arbitrate and accept one AR
// ADDR  | registered AR presented to the fabric until m_axi_arready
// DATA  | fabric R forwarded to the granted requester until handshake
// ERR   | (timeout build) SLVERR returned to the granted requester
// DRAIN | (timeout build) discard one late fabric R beat, no new grants
module axi_lite_rd_arbiter #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int PROT_WIDTH     = 3,
  parameter int RESP_WIDTH     = 2,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                  CLK,
  input  logic                  RSTN,
  input  logic                  s0_axi_arvalid,
  output logic                  s0_axi_arready,
  input  logic [ADDR_WIDTH-1:0] s0_axi_araddr,
  input  logic [PROT_WIDTH-1:0] s0_axi_arprot,
  output logic                  s0_axi_rvalid,
  input  logic                  s0_axi_rready,
  output logic [DATA_WIDTH-1:0] s0_axi_rdata,
  output logic [RESP_WIDTH-1:0] s0_axi_rresp,
  input  logic                  s1_axi_arvalid,
  output logic                  s1_axi_arready,
  input  logic [ADDR_WIDTH-1:0] s1_axi_araddr,
  input  logic [PROT_WIDTH-1:0] s1_axi_arprot,
  output logic                  s1_axi_rvalid,
  input  logic                  s1_axi_rready,
  output logic [DATA_WIDTH-1:0] s1_axi_rdata,
  output logic [RESP_WIDTH-1:0] s1_axi_rresp,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  output logic [ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [PROT_WIDTH-1:0] m_axi_arprot,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready,
  input  logic [DATA_WIDTH-1:0] m_axi_rdata,
  input  logic [RESP_WIDTH-1:0] m_axi_rresp
);

`ifdef AXI_RD_ARB_TIMEOUT_EN
  typedef enum logic [2:0] {IDLE, ADDR, DATA, ERR, DRAIN} state_e;
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  logic [TMO_W-1:0] tmo_cnt_q;
`else
  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_e;
  // TIMEOUT_CYCLES only sizes the optional watchdog.
  logic unused_tmo;
  assign unused_tmo = (TIMEOUT_CYCLES != 0);
`endif

  state_e                state_q;
  logic                  grant_q;
  logic                  last_grant_q;
  logic                  arvalid_q;
  logic [ADDR_WIDTH-1:0] araddr_q;
  logic [PROT_WIDTH-1:0] arprot_q;

  logic                  grant_d;
  logic                  ar_accept;
  logic                  s_rready;
  logic                  rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_data;
  logic [RESP_WIDTH-1:0] rsp_resp;

  // On a tie the requester that did not win last time goes next; otherwise
  // the only requester present wins.
  assign grant_d   = (s0_axi_arvalid && s1_axi_arvalid) ? ~last_grant_q : s1_axi_arvalid;
  // Qualified with RSTN so no requester sees arready while reset is held.
  assign ar_accept = (state_q == IDLE) && (s0_axi_arvalid || s1_axi_arvalid) && RSTN;

  assign s0_axi_arready = ar_accept && !grant_d;
  assign s1_axi_arready = ar_accept && grant_d;

  assign s_rready = grant_q ? s1_axi_rready : s0_axi_rready;

  always_comb begin
    rsp_valid    = 1'b0;
    rsp_data     = '0;
    rsp_resp     = '0;
    m_axi_rready = 1'b0;
    case (state_q)
      DATA: begin
        rsp_valid    = m_axi_rvalid;
        rsp_data     = m_axi_rdata;
        rsp_resp     = m_axi_rresp;
        m_axi_rready = s_rready;
      end
`ifdef AXI_RD_ARB_TIMEOUT_EN
      ERR: begin
        rsp_valid = 1'b1;
        rsp_resp  = RESP_WIDTH'(2'b10);
      end
      DRAIN: m_axi_rready = 1'b1;
`endif
      default: ;
    endcase
  end

  assign s0_axi_rvalid = rsp_valid && !grant_q;
  assign s1_axi_rvalid = rsp_valid && grant_q;
  assign s0_axi_rdata  = grant_q ? '0 : rsp_data;
  assign s1_axi_rdata  = grant_q ? rsp_data : '0;
  assign s0_axi_rresp  = grant_q ? '0 : rsp_resp;
  assign s1_axi_rresp  = grant_q ? rsp_resp : '0;

  assign m_axi_arvalid = arvalid_q;
  assign m_axi_araddr  = araddr_q;
  assign m_axi_arprot  = arprot_q;

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q      <= IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      arvalid_q    <= 1'b0;
      araddr_q     <= '0;
      arprot_q     <= '0;
`ifdef AXI_RD_ARB_TIMEOUT_EN
      tmo_cnt_q    <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (ar_accept) begin
            grant_q   <= grant_d;
            araddr_q  <= grant_d ? s1_axi_araddr : s0_axi_araddr;
            arprot_q  <= grant_d ? s1_axi_arprot : s0_axi_arprot;
            arvalid_q <= 1'b1;
            state_q   <= ADDR;
          end
        end
        ADDR: begin
          if (m_axi_arready) begin
            arvalid_q <= 1'b0;
            state_q   <= DATA;
`ifdef AXI_RD_ARB_TIMEOUT_EN
            tmo_cnt_q <= '0;
`endif
          end
        end
        DATA: begin
          if (m_axi_rvalid && s_rready) begin
            last_grant_q <= grant_q;
            state_q      <= IDLE;
          end
`ifdef AXI_RD_ARB_TIMEOUT_EN
          else if (!m_axi_rvalid) begin
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
            if (tmo_cnt_q == TMO_LAST) state_q <= ERR;
          end
`endif
        end
`ifdef AXI_RD_ARB_TIMEOUT_EN
        ERR: begin
          if (s_rready) begin
            last_grant_q <= grant_q;
            state_q      <= DRAIN;
          end
        end
        DRAIN: begin
          if (m_axi_rvalid) state_q <= IDLE;
        end
`endif
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/axi_lite_rd_arbiter.md
Name: axi_lite_rd_arbiter

Overview:
Shares one AXI4-Lite read port to the memory fabric between two read requesters inside the core. Requester 0 is instruction fetch. Requester 1 is a data or debug read path. Sequences one outstanding transaction at a time: arbitrate, forward the AR, then route R back to the granted requester. Fair round-robin grant; registered AR toward the fabric.

Parameters:
ADDR_WIDTH, 32, address width
DATA_WIDTH, 32, read data width
PROT_WIDTH, 3, AxPROT width
RESP_WIDTH, 2, RRESP width
TIMEOUT_CYCLES, 256, R-wait limit (used only with the optional feature)

Ports:
CLK  in  1  single clock, all logic rising-edge
RSTN  in  1  asynchronous, active-low reset
s0_axi_arvalid / s1_axi_arvalid  in  1  requester AR valid
s0_axi_arready / s1_axi_arready  out  1  requester AR accept
s0_axi_araddr / s1_axi_araddr  in  ADDR_WIDTH  requester address
s0_axi_arprot / s1_axi_arprot  in  PROT_WIDTH  requester prot
s0_axi_rvalid / s1_axi_rvalid  out  1  requester R valid
s0_axi_rready / s1_axi_rready  in  1  requester R ready
s0_axi_rdata / s1_axi_rdata  out  DATA_WIDTH  requester read data
s0_axi_rresp / s1_axi_rresp  out  RESP_WIDTH  requester response
m_axi_arvalid  out  1  fabric AR valid (registered)
m_axi_arready  in  1  fabric AR ready
m_axi_araddr  out  ADDR_WIDTH  fabric address (registered)
m_axi_arprot  out  PROT_WIDTH  fabric prot (registered)
m_axi_rvalid  in  1  fabric R valid
m_axi_rready  out  1  fabric R ready
m_axi_rdata  in  DATA_WIDTH  fabric data
m_axi_rresp  in  RESP_WIDTH  fabric response

Behaviour:
- Reset (RSTN low, async):
  - state=IDLE, grant=0, last_grant=1.
  - m_axi_arvalid=0, m_axi_araddr=0, m_axi_arprot=0.
  - All s*_arready and s*_rvalid=0.
  - All s*_rdata and s*_rresp=0.
  - m_axi_rready=0.
- States: IDLE, ADDR, DATA.
- IDLE, arbitration:
  - Only one arvalid: that requester wins.
  - Both arvalid: the requester != last_grant wins. After reset, requester 0 wins the first tie.
  - Winner's s*_arready=1 combinationally in the same cycle. Its araddr/arprot are latched into the m_axi regs and grant is recorded.
  - Next state ADDR, with m_axi_arvalid=1 from the next cycle.
- ADDR:
  - m_axi_arvalid held at 1 with stable addr/prot until m_axi_arready=1.
  - Then m_axi_arvalid=0 on the next edge; go to DATA.
- DATA:
  - Granted requester sees s_rvalid=m_axi_rvalid, s_rdata=m_axi_rdata, s_rresp=m_axi_rresp.
  - m_axi_rready=s_rready of the granted requester.
  - On handshake (m_axi_rvalid & granted rready): last_grant=grant, go to IDLE.
- Non-granted requester: arready=0, rvalid=0, rdata=0, rresp=0 at all times.
- m_axi_rready=0 outside DATA. A stray m_axi_rvalid in IDLE/ADDR is ignored and not forwarded.
- Latency:
  - Minimum 3 cycles from arvalid acceptance to the R handshake, assuming zero fabric latency.
  - Back-to-back: next grant is possible the cycle after the R handshake (IDLE is re-entered).
- Fairness: with continuous requests from both requesters, grants strictly alternate 0,1,0,1.
- Requester arvalid with no arready is held pending with no side effect. A requester deasserting arvalid before arready is a protocol violation and is not handled.
- Reset mid-transaction returns the block to IDLE. The in-flight response is lost, so the fabric shares RSTN.

Optional Feature:
- Macro: AXI_RD_ARB_TIMEOUT_EN.
- With the macro:
  - A counter clears on entry to DATA and increments each DATA cycle while m_axi_rvalid=0.
  - When the counter reaches TIMEOUT_CYCLES, go to ERR.
  - ERR: granted s_rvalid=1, s_rresp=2'b10 (SLVERR), s_rdata=0 until s_rready.
  - Then DRAIN: m_axi_rready=1 and no grants until one m_axi_rvalid beat is discarded; then IDLE.
- Without the macro: DATA waits indefinitely; no counter, ERR or DRAIN logic exists.

Test Plan:
- s0 arvalid, araddr=0x0000_1000, fabric arready and rvalid immediate, rdata=0xDEAD_BEEF -> s0_arready in cycle 0; m_axi_arvalid with addr 0x1000 in cycle 1; s0_rvalid, rdata 0xDEADBEEF, rresp 0 in cycle 2.
- s0 and s1 both assert arvalid continuously for 4 transactions after reset -> grant order 0,1,0,1; s1 never sees rvalid during s0 transactions.
- Fabric holds arready=0 for 5 cycles -> m_axi_arvalid=1 and araddr stable all 5 cycles; s1 request issued meanwhile gets arready=0.
- In DATA, s1_rready=0 for 3 cycles while m_axi_rvalid=1 with rdata=0x1234_5678 -> m_axi_rready=0 and data held; completes on s1_rready=1.
- RSTN low while in DATA -> all outputs return to reset values immediately; the next request grants s0 on a tie.
- With AXI_RD_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=8, fabric never returns R -> s0 gets rvalid with rresp=2'b10 and rdata=0 after 8 DATA cycles; a later fabric R is dropped; then IDLE.
